// File: rtl/i2s_pkg.sv
// i2s_pkg: shared constants and types for the I2S serial receiver.
//   CHNL_W_DEF : default bits per channel slot
//   CNT_W      : width of the per-word bit counter
//   state_t    : framing FSM states
package i2s_pkg;

  localparam int CHNL_W_DEF = 24;
  localparam int CNT_W      = 5;

  typedef enum logic [1:0] {
    IDLE = 2'd0,  // waiting for a ws falling edge
    SYNC = 2'd1,  // swallowing the one-bit I2S delay slot
    LFT  = 2'd2,  // shifting in the left word
    RGHT = 2'd3   // shifting in the right word
  } state_t;

endpackage

// File: rtl/i2s_sync_edge.sv
// i2s_sync_edge: two-flop synchronizer for an asynchronous level plus one
// extra flop so edges of the synchronized level can be detected in clk.
// Ports:
//   clk, rst_n : system clock, asynchronous active-low reset
//   din        : asynchronous input level
//   lvl        : synchronized level
//   rise, fall : one-clk strobes on synchronized rising / falling edges
module i2s_sync_edge (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic lvl,
  output logic rise,
  output logic fall
);

  // sr[0], sr[1] form the metastability chain; sr[2] is the previous level.
  logic [2:0] sr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sr <= '0;
    end else begin
      sr <= {sr[1:0], din};
    end
  end

  assign lvl  = sr[1];
  assign rise = sr[1] & ~sr[2];
  assign fall = ~sr[1] & sr[2];

endmodule

// File: rtl/i2s_serf_rx.sv
// i2s_serf_rx: Philips-format I2S slave receiver. Oversamples sclk/ws/data
// in clk, locks to the frame on a ws falling edge and deserializes 24-bit
// left/right words, MSB first, with the standard one-bit delay after ws.
// Ports:
//   clk, rst_n           : system clock, asynchronous active-low reset
//   I2S_sclk             : bit clock (asynchronous, period >= 8 clk)
//   I2S_ws               : word select, 0 = left, 1 = right
//   I2S_data             : serial data, sampled on sclk rising edges
//   lft_chnnl/rght_chnnl : sample pair, guaranteed only while vld is high
//   vld                  : one-clk strobe per received left/right pair
//
// Handshake: vld is a pure strobe with no ready/backpressure; the consumer
// must capture lft_chnnl and rght_chnnl in the cycle vld is high.
module i2s_serf_rx
  import i2s_pkg::*;
#(
  parameter int CHNL_W = CHNL_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              I2S_sclk,
  input  logic              I2S_ws,
  input  logic              I2S_data,
  output logic [CHNL_W-1:0] lft_chnnl,
  output logic [CHNL_W-1:0] rght_chnnl,
  output logic              vld
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CHNL_W);

  logic sclk_lvl, sclk_rise, sclk_fall;
  logic ws_lvl, ws_rise, ws_fall;
  logic [1:0] data_sr;

  i2s_sync_edge u_sclk_sync (
    .clk  (clk),
    .rst_n(rst_n),
    .din  (I2S_sclk),
    .lvl  (sclk_lvl),
    .rise (sclk_rise),
    .fall (sclk_fall)
  );

  i2s_sync_edge u_ws_sync (
    .clk  (clk),
    .rst_n(rst_n),
    .din  (I2S_ws),
    .lvl  (ws_lvl),
    .rise (ws_rise),
    .fall (ws_fall)
  );

  // Data only needs a level, so it gets the bare two-flop chain. Its
  // latency matches the sclk chain, keeping data aligned with sclk_rise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_sr <= '0;
    end else begin
      data_sr <= {data_sr[0], I2S_data};
    end
  end

  // Only sclk_rise and ws_fall drive the framing; the other edge strobes
  // and the synced sclk level are unused by this block.
  logic unused_edges;
  assign unused_edges = sclk_lvl ^ sclk_fall ^ ws_rise;

  // Observable FSM state for checkers.
  state_t                state, state_nxt;
  logic [CNT_W-1:0]      cnt, cnt_nxt, cnt_inc;
  logic [2*CHNL_W-1:0]   shift, shift_nxt;
  logic                  vld_nxt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
      shift <= '0;
      vld   <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      shift <= shift_nxt;
      vld   <= vld_nxt;
    end
  end

  assign cnt_inc = cnt + 1'b1;

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    shift_nxt = shift;
    vld_nxt   = 1'b0;
    case (state)
      IDLE: begin
        if (ws_fall) state_nxt = SYNC;
      end
      SYNC: begin
        // This rise carries the previous frame's right LSB; drop it.
        if (sclk_rise) begin
          cnt_nxt   = '0;
          state_nxt = LFT;
        end
      end
      LFT: begin
        if (sclk_rise) begin
          shift_nxt = {shift[2*CHNL_W-2:0], data_sr[1]};
          if (cnt_inc == CNT_LAST) begin
            cnt_nxt   = '0;
            state_nxt = RGHT;
          end else begin
            cnt_nxt = cnt_inc;
          end
        end
      end
      RGHT: begin
        if (sclk_rise) begin
          shift_nxt = {shift[2*CHNL_W-2:0], data_sr[1]};
          if (cnt_inc == CNT_LAST) begin
            cnt_nxt = '0;
            // The right LSB rides on rise #1 of the next frame, so ws must
            // already be low here; if not, framing was lost.
            if (!ws_lvl) begin
              vld_nxt   = 1'b1;
              state_nxt = LFT;
            end else begin
              state_nxt = IDLE;
            end
          end else begin
            cnt_nxt = cnt_inc;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign lft_chnnl  = shift[2*CHNL_W-1:CHNL_W];
  assign rght_chnnl = shift[CHNL_W-1:0];

endmodule

// File: tb/tb_i2s_serf_rx.sv
// tb_i2s_serf_rx: directed bench for the I2S receiver. A bit-level BFM
// drives sclk = clk/32; a frame-level model predicts which left/right pairs
// must surface on vld and a negedge compare process checks every vld cycle
// and every in-reset cycle against it.
module tb_i2s_serf_rx;
  import i2s_pkg::*;

  localparam int W    = 24;
  localparam int HALF = 16;  // clk cycles per sclk half period

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         sclk = 1'b1;
  logic         ws = 1'b1;
  logic         data = 1'b0;
  logic [W-1:0] lft, rght;
  logic         vld;

  i2s_serf_rx #(.CHNL_W(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .I2S_sclk  (sclk),
    .I2S_ws    (ws),
    .I2S_data  (data),
    .lft_chnnl (lft),
    .rght_chnnl(rght),
    .vld       (vld)
  );

  // ---------------- clock / cycle counter ----------------
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- bookkeeping ----------------
  int n_checks = 0;
  int n_errs   = 0;

  task automatic chk(input string name, input logic [47:0] act, input logic [47:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errs++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- frame-level model ----------------
  logic [47:0] exp_q[$];       // {left, right} pairs that must appear on vld
  logic [47:0] pending;        // last fully sent frame, awaiting its right LSB
  bit          pending_valid = 0;
  logic        prev_lsb = 1'b0;
  bit          got_rst = 0;

  // ---------------- compare process ----------------
  int           vld_cnt = 0;
  int           sync_entries = 0;
  int           vld_cyc[$];
  logic [W-1:0] last_l = '0, last_r = '0;
  state_t       prev_st = IDLE;

  always @(negedge clk) begin
    if (!rst_n) begin
      chk("rst_vld", 48'(vld), 48'd0);
      chk("rst_lft", 48'(lft), 48'd0);
      chk("rst_rght", 48'(rght), 48'd0);
    end else begin
      if (dut.state == SYNC && prev_st != SYNC) sync_entries++;
      if (vld) begin
        vld_cnt++;
        vld_cyc.push_back(cyc);
        last_l = lft;
        last_r = rght;
        if (exp_q.size() == 0) begin
          n_checks++;
          n_errs++;
          $display("FAIL unexpected_vld: got lft=%0h rght=%0h expected no vld (t=%0t)", lft, rght, $time);
        end else begin
          logic [47:0] e;
          e = exp_q.pop_front();
          chk("vld_lft", 48'(lft), 48'(e[47:24]));
          chk("vld_rght", 48'(rght), 48'(e[23:0]));
        end
      end
    end
    prev_st = dut.state;
  end

  // ---------------- driver tasks ----------------
  task automatic wait_clk(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // One sclk period: ws/data change with the falling edge, sampled on rise.
  // do_rst pulses rst_n asynchronously in the middle of the low phase.
  task automatic sclk_bit(input logic w, input logic d, input bit do_rst);
    sclk = 1'b0;
    ws   = w;
    data = d;
    if (do_rst) begin
      wait_clk(8);
      #2 rst_n = 1'b0;
      #1;
      chk("async_rst_lft", 48'(lft), 48'd0);
      chk("async_rst_rght", 48'(rght), 48'd0);
      chk("async_rst_vld", 48'(vld), 48'd0);
      wait_clk(3);
      rst_n = 1'b1;
      got_rst = 1;
      pending_valid = 0;
      wait_clk(HALF - 11);
    end else begin
      wait_clk(HALF);
    end
    sclk = 1'b1;
    wait_clk(HALF);
  endtask

  // 48 bits of one I2S frame: bit 0 carries the previous right LSB.
  // rst_at selects a bit index at which to pulse reset (-1 for none).
  task automatic send_frame(input logic [W-1:0] l, input logic [W-1:0] r, input int rst_at);
    got_rst = 0;
    if (pending_valid) exp_q.push_back(pending);
    pending_valid = 0;
    for (int i = 0; i < W; i++)
      sclk_bit(1'b0, (i == 0) ? prev_lsb : l[W-i], i == rst_at);
    for (int i = 0; i < W; i++)
      sclk_bit(1'b1, (i == 0) ? l[0] : r[W-i], (i + W) == rst_at);
    prev_lsb = r[0];
    if (!got_rst) begin
      pending = {l, r};
      pending_valid = 1;
    end
  endtask

  // Trailing ws-low bit that delivers the last right LSB.
  task automatic send_tail();
    if (pending_valid) exp_q.push_back(pending);
    pending_valid = 0;
    sclk_bit(1'b0, prev_lsb, 0);
    wait_clk(8);
  endtask

  // ws held high where the right LSB should arrive: that frame is lost.
  task automatic send_ws_high(input int n);
    pending_valid = 0;
    for (int i = 0; i < n; i++) sclk_bit(1'b1, 1'b0, 0);
  endtask

  task automatic restart();
    chk("no_missed_vld", 48'(exp_q.size()), 48'd0);
    exp_q.delete();
    ws = 1'b1;
    sclk = 1'b1;
    rst_n = 1'b0;
    wait_clk(3);
    rst_n = 1'b1;
    pending_valid = 0;
    prev_lsb = 1'b0;
    sclk_bit(1'b1, 1'b0, 0);
    sclk_bit(1'b1, 1'b0, 0);
  endtask

  // ---------------- directed tests ----------------
  initial begin : main
    int base;
    int s0;

    // Reset held with sclk and data toggling.
    for (int i = 0; i < 3; i++) sclk_bit(1'b1, i[0], 0);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) sclk_bit(1'b1, i[0], 0);
    chk("idle_no_vld", 48'(vld_cnt), 48'd0);
    chk("idle_state", 48'(dut.state), 48'(IDLE));

    // Single frame.
    restart();
    base = vld_cnt;
    send_frame(24'hABCDEF, 24'h123456, -1);
    send_tail();
    chk("single_cnt", 48'(vld_cnt - base), 48'd1);
    chk("single_lft", 48'(last_l), 48'hABCDEF);
    chk("single_rght", 48'(last_r), 48'h123456);

    // Streaming tone samples, back to back.
    restart();
    base = vld_cnt;
    s0 = sync_entries;
    send_frame(24'h000000, 24'h000000, -1);
    send_frame(24'h03D600, 24'h03D600, -1);
    send_frame(24'h078D00, 24'h078D00, -1);
    send_tail();
    chk("stream_cnt", 48'(vld_cnt - base), 48'd3);
    chk("stream_lft_hi", 48'(last_l[23:8]), 48'h078D);
    chk("stream_sync_once", 48'(sync_entries - s0), 48'd1);
    chk("stream_gap1", 48'(vld_cyc[base+1] - vld_cyc[base]), 48'd1536);
    chk("stream_gap2", 48'(vld_cyc[base+2] - vld_cyc[base+1]), 48'd1536);

    // Negative full scale / positive full scale.
    restart();
    send_frame(24'h800000, 24'h7FFFFF, -1);
    send_tail();
    chk("neg_lft", 48'(last_l), 48'h800000);
    chk("pos_rght", 48'(last_r), 48'h7FFFFF);

    // Lost sync: second frame ends with ws still high.
    restart();
    base = vld_cnt;
    send_frame(24'h5A5A5A, 24'hA5A5A5, -1);
    send_frame(24'h333333, 24'h444444, -1);
    send_ws_high(4);
    chk("lost_cnt", 48'(vld_cnt - base), 48'd1);
    chk("lost_state", 48'(dut.state), 48'(IDLE));
    send_frame(24'h111111, 24'h222222, -1);
    send_tail();
    chk("resync_cnt", 48'(vld_cnt - base), 48'd2);
    chk("resync_lft", 48'(last_l), 48'h111111);
    chk("resync_rght", 48'(last_r), 48'h222222);

    // Mid-frame reset halfway through a left word.
    restart();
    base = vld_cnt;
    send_frame(24'h0F0F0F, 24'hF0F0F0, -1);
    send_frame(24'hDEAD00, 24'h00BEEF, 12);
    send_frame(24'h654321, 24'h0ABCDE, -1);
    send_tail();
    chk("midrst_cnt", 48'(vld_cnt - base), 48'd2);
    chk("midrst_lft", 48'(last_l), 48'h654321);
    chk("midrst_rght", 48'(last_r), 48'h0ABCDE);

    wait_clk(20);
    chk("final_queue_empty", 48'(exp_q.size()), 48'd0);
    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule
